// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants for the 800x600 raster path: default mode timing, counter
// widths and the 6-bit RGB pixel layout. Used by vga_timing and by the pixel
// sources that consume cntr_h/cntr_v.
package vga_timing_pkg;

   // 800x600@72 with a 50 MHz pixel clock
   localparam int H_VISIBLE_DEF = 800;
   localparam int H_FRONT_DEF   = 56;
   localparam int H_SYNC_DEF    = 120;
   localparam int H_BACK_DEF    = 64;
   localparam int V_VISIBLE_DEF = 600;
   localparam int V_FRONT_DEF   = 37;
   localparam int V_SYNC_DEF    = 6;
   localparam int V_BACK_DEF    = 23;
   localparam int HSYNC_POL_DEF = 1;
   localparam int VSYNC_POL_DEF = 1;

   localparam int H_WIDTH   = 11;
   localparam int V_WIDTH   = 10;
   localparam int RGB_WIDTH = 6;

   // DAC pin order {R[1:0],G[1:0],B[1:0]}
   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
   } rgb_t;

   function automatic int axis_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a wrapping position counter plus decode of the visible
// region and the sync window for that axis.
// Ports:
//   clk, rst  pixel clock, asynchronous active-high reset
//   inc       advance the count this clock
//   count     current position, 0..TOTAL-1
//   wrap      inc is set and count is at TOTAL-1 (count returns to 0 next)
//   visible   count < VISIBLE
//   in_sync   count in [VISIBLE+FRONT, VISIBLE+FRONT+SYNC)
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF,
   parameter int WIDTH   = H_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             visible,
   output logic             in_sync
);

   localparam int TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
   localparam int SYNC_START = VISIBLE + FRONT;
   localparam int SYNC_END   = SYNC_START + SYNC;

   // One extra bit so a window ending exactly at 2**WIDTH still compares
   // correctly.
   localparam logic [WIDTH:0] LAST_C       = (WIDTH+1)'(TOTAL - 1);
   localparam logic [WIDTH:0] VISIBLE_C    = (WIDTH+1)'(VISIBLE);
   localparam logic [WIDTH:0] SYNC_START_C = (WIDTH+1)'(SYNC_START);
   localparam logic [WIDTH:0] SYNC_END_C   = (WIDTH+1)'(SYNC_END);

   if (TOTAL < 1 || TOTAL > (1 << WIDTH)) begin : g_bad_total
      $error("vga_axis_counter: axis total does not fit the counter width");
   end

   logic [WIDTH:0] count_x;

   assign count_x = {1'b0, count};
   assign wrap    = inc && (count_x == LAST_C);
   assign visible = (count_x < VISIBLE_C);
   assign in_sync = (count_x >= SYNC_START_C) && (count_x < SYNC_END_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/vga_timing.sv
// vga_timing
// Raster timing generator and registered pixel output stage.
// The h/v counters drive cntr_h/cntr_v straight from registers; the pixel
// source answers combinationally on pixel_in, and one output register stage
// captures rgb, blank, hsync, vsync and frame_start for that same position,
// so all five outputs are aligned one clock behind the counters.
// Ports:
//   clk, rst     pixel clock, asynchronous active-high reset
//   pixel_in     6-bit pixel for the current cntr_h/cntr_v
//   cntr_h       horizontal position 0..H_TOTAL-1
//   cntr_v       vertical position 0..V_TOTAL-1
//   rgb          registered pixel {R[1:0],G[1:0],B[1:0]}, 0 when blanked
//   hsync/vsync  registered syncs at the configured polarity
//   blank        registered, 1 outside the visible area
//   frame_start  one-cycle pulse with output pixel (0,0)
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int   H_VISIBLE = H_VISIBLE_DEF,
   parameter int   H_FRONT   = H_FRONT_DEF,
   parameter int   H_SYNC    = H_SYNC_DEF,
   parameter int   H_BACK    = H_BACK_DEF,
   parameter int   V_VISIBLE = V_VISIBLE_DEF,
   parameter int   V_FRONT   = V_FRONT_DEF,
   parameter int   V_SYNC    = V_SYNC_DEF,
   parameter int   V_BACK    = V_BACK_DEF,
   parameter logic HSYNC_POL = 1'(HSYNC_POL_DEF),
   parameter logic VSYNC_POL = 1'(VSYNC_POL_DEF)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [RGB_WIDTH-1:0] pixel_in,
   output logic [H_WIDTH-1:0]   cntr_h,
   output logic [V_WIDTH-1:0]   cntr_v,
   output logic [RGB_WIDTH-1:0] rgb,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 blank,
   output logic                 frame_start
);

   logic [H_WIDTH-1:0] h_count;
   logic [V_WIDTH-1:0] v_count;
   logic               h_wrap;
   logic               h_visible;
   logic               h_in_sync;
   logic               v_wrap_unused;
   logic               v_visible;
   logic               v_in_sync;
   logic               visible;
   rgb_t               rgb_q;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .WIDTH   (H_WIDTH)
   ) u_h_axis (
      .clk     (clk),
      .rst     (rst),
      .inc     (1'b1),
      .count   (h_count),
      .wrap    (h_wrap),
      .visible (h_visible),
      .in_sync (h_in_sync)
   );

   // The vertical axis steps once per line, so vsync is line-granular and
   // changes on the same clock the line wraps.
   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .WIDTH   (V_WIDTH)
   ) u_v_axis (
      .clk     (clk),
      .rst     (rst),
      .inc     (h_wrap),
      .count   (v_count),
      .wrap    (v_wrap_unused),
      .visible (v_visible),
      .in_sync (v_in_sync)
   );

   assign visible = h_visible && v_visible;
   assign cntr_h  = h_count;
   assign cntr_v  = v_count;
   assign rgb     = rgb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_q       <= '0;
         blank       <= 1'b1;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         frame_start <= 1'b0;
      end else begin
         rgb_q       <= visible ? rgb_t'(pixel_in) : '0;
         blank       <= ~visible;
         hsync       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
         frame_start <= (h_count == '0) && (v_count == '0);
      end
   end

endmodule
